// File: rtl/gemm_result_collector_pkg.sv
// Shared helpers for the GEMM result collector: array latency and result-entry sizing.
package gemm_result_collector_pkg;

  // Cycles from an input vector entering the array to its result leaving it.
  function automatic int gemm_latency(input int sa_size);
    return 2 * sa_size;
  endfunction

  // Bits in one buffered result entry: {last, data vector}.
  function automatic int entry_width(input int sa_size, input int elem_w);
    return sa_size * elem_w + 1;
  endfunction

endpackage

// File: rtl/gemm_result_collector_fifo.sv
// Synchronous FIFO with occupancy count; a push and a pop in the same cycle are
// both honoured even when full, so the caller decides when a push is legal.
module gemm_result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             not_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout      = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);

endmodule

// File: rtl/gemm_result_collector.sv
// Collects systolic-array output vectors, keeps only those tagged as real input,
// frames them into matrices and buffers them for a valid/ready consumer.
module gemm_result_collector
  import gemm_result_collector_pkg::*;
#(
  parameter int SA_SIZE                = 2,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int FIFO_DEPTH             = 4,
  parameter int ROWS_PER_MATRIX        = 2
) (
  input  logic                                                clk,
  input  logic                                                resetn,
  input  logic                                                clr,
  input  logic                                                in_real,
  input  logic                                                sa_output_valid,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]      sa_outputs,
  output logic                                                m_valid,
  input  logic                                                m_ready,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]      m_data,
  output logic                                                m_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]                     count,
  output logic                                                overflow
);

  localparam int LAT     = gemm_latency(SA_SIZE);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ROW_W   = (ROWS_PER_MATRIX > 1) ? $clog2(ROWS_PER_MATRIX) : 1;
  localparam int ENTRY_W = entry_width(SA_SIZE, WEIGHT_ACTIVATION_SIZE);

  typedef struct packed {
    logic                                           last;
    logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] data;
  } entry_t;

  logic [LAT-1:0]     tag_q, tag_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               overflow_q, overflow_d;
  logic               tag_out, cap, pop, push, row_is_last, fifo_full;
  entry_t             wr_entry, rd_entry;
  logic [ENTRY_W-1:0] wr_bits, rd_bits;

  assign tag_out     = tag_q[LAT-1];
  assign cap         = sa_output_valid && tag_out;
  assign row_is_last = (row_q == ROW_W'(ROWS_PER_MATRIX - 1));

  // Stream handshake: a beat transfers when m_valid && m_ready at a rising edge;
  // m_valid, m_data and m_last stay unchanged until that beat transfers.
  assign pop  = m_valid && m_ready;
  assign push = cap && (!fifo_full || pop);

  always_comb begin
    tag_d      = {tag_q[LAT-2:0], in_real};
    row_d      = row_q;
    overflow_d = overflow_q | (cap && !push);
    // Dropped captures still advance the row so matrix framing survives loss.
    if (cap) row_d = row_is_last ? '0 : row_q + ROW_W'(1);
    if (clr) begin
      tag_d      = '0;
      row_d      = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_entry.last = row_is_last;
  assign wr_entry.data = sa_outputs;
  assign wr_bits       = wr_entry;
  assign rd_entry      = rd_bits;

  gemm_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .din       (wr_bits),
    .dout      (rd_bits),
    .count     (count),
    .full      (fifo_full),
    .not_empty (m_valid)
  );

  assign m_data   = rd_entry.data;
  assign m_last   = rd_entry.last;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gemm_result_collector.sv
// Directed bench for gemm_result_collector: a per-cycle vector table plus
// hand-written clr and mid-stream reset sequences.
module tb_gemm_result_collector;

  logic            clk;
  logic            resetn;
  logic            clr;
  logic            in_real;
  logic            sa_output_valid;
  logic [1:0][7:0] sa_outputs;
  logic            m_valid;
  logic            m_ready;
  logic [1:0][7:0] m_data;
  logic            m_last;
  logic [2:0]      count;
  logic            overflow;

  int tests;
  int fails;

  typedef struct {
    logic        ir;
    logic        sv;
    logic [15:0] d;
    logic        rdy;
    logic        cl;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    int          ec;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  gemm_result_collector #(
    .SA_SIZE                (2),
    .WEIGHT_ACTIVATION_SIZE (8),
    .FIFO_DEPTH             (4),
    .ROWS_PER_MATRIX        (2)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .clr             (clr),
    .in_real         (in_real),
    .sa_output_valid (sa_output_valid),
    .sa_outputs      (sa_outputs),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .count           (count),
    .overflow        (overflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] v2(input int a, input int b);
    return {8'(a), 8'(b)};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic sv, input logic [15:0] d,
                       input logic rdy, input logic cl);
    in_real         = ir;
    sa_output_valid = sv;
    sa_outputs      = d;
    m_ready         = rdy;
    clr             = cl;
  endtask

  task automatic add(input logic ir, input logic sv, input logic [15:0] d,
                     input logic rdy, input logic cl, input logic ev,
                     input logic [15:0] ed, input logic el, input int ec,
                     input logic eo);
    vec_t v;
    v.ir = ir; v.sv = sv; v.d = d; v.rdy = rdy; v.cl = cl;
    v.ev = ev; v.ed = ed; v.el = el; v.ec = ec; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic build_table();
    // Basic: one real vector, visible the cycle after capture
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_idle(3);
    add(0, 1, v2(6, 10), 0, 0, 1, v2(6, 10), 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Framing: two rows, last flag on the second
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_idle(2);
    add(0, 1, v2(6, 10), 1, 0, 1, v2(6, 10), 0, 1, 0);
    add(0, 1, v2(9, 4), 1, 0, 1, v2(9, 4), 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Bubble drop: middle vector has no real tag
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_idle(1);
    add(0, 1, v2(1, 1), 0, 0, 1, v2(1, 1), 0, 1, 0);
    add(0, 1, v2(2, 2), 0, 0, 1, v2(1, 1), 0, 1, 0);
    add(0, 1, v2(3, 3), 0, 0, 1, v2(1, 1), 0, 2, 0);
    add(0, 0, 0, 1, 0, 1, v2(3, 3), 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Tag arrives with sa_output_valid low: discarded, row does not advance
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_idle(3);
    add(0, 1, v2(7, 7), 0, 0, 1, v2(7, 7), 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Backpressure and overflow: six captures into a depth-4 FIFO
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++)
      add(k <= 2, 1, v2(k, k), 0, 0, 1, v2(1, 1), 0, (k < 4) ? k : 4, k >= 5);
    add(0, 0, 0, 1, 0, 1, v2(2, 2), 1, 3, 1);
    add(0, 0, 0, 1, 0, 1, v2(3, 3), 0, 2, 1);
    add(0, 0, 0, 1, 0, 1, v2(4, 4), 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Full FIFO with simultaneous push and pop
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++)
      add(k == 1, 1, v2(k, k), 0, 0, 1, v2(1, 1), 0, k, 0);
    add(0, 1, v2(5, 5), 1, 0, 1, v2(2, 2), 1, 4, 0);
    add(0, 0, 0, 1, 0, 1, v2(3, 3), 0, 3, 0);
    add(0, 0, 0, 1, 0, 1, v2(4, 4), 1, 2, 0);
    add(0, 0, 0, 1, 0, 1, v2(5, 5), 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  // Three rows buffered, more tags still in the delay line.
  task automatic fill_three();
    for (int c = 0; c <= 6; c++) begin
      drive(c <= 5, c >= 4, v2(c, c), 0, 0);
      step();
    end
    chk("fill_count", 0, count, 3);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 0, m_valid, 0);
    chk("rst_data", 0, m_data, 0);
    chk("rst_last", 0, m_last, 0);
    chk("rst_count", 0, count, 0);
    chk("rst_overflow", 0, overflow, 0);
    resetn = 1'b1;

    build_table();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ir, vecs[i].sv, vecs[i].d, vecs[i].rdy, vecs[i].cl);
      step();
      chk("valid", i, m_valid, vecs[i].ev);
      chk("count", i, count, vecs[i].ec);
      chk("overflow", i, overflow, vecs[i].eo);
      if (vecs[i].ev) begin
        chk("data", i, m_data, vecs[i].ed);
        chk("last", i, m_last, vecs[i].el);
      end
    end

    // clr with data buffered and tags in flight
    fill_three();
    drive(0, 1, v2(8, 8), 0, 1);
    step();
    chk("clr_valid", 0, m_valid, 0);
    chk("clr_count", 0, count, 0);
    chk("clr_overflow", 0, overflow, 0);
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, v2(8, 8), 0, 0);
      step();
      chk("clr_no_cap", c, count, 0);
    end

    // Asynchronous reset mid-stream
    fill_three();
    drive(0, 1, v2(8, 8), 0, 0);
    resetn = 1'b0;
    #1;
    chk("arst_valid", 0, m_valid, 0);
    chk("arst_count", 0, count, 0);
    chk("arst_overflow", 0, overflow, 0);
    chk("arst_data", 0, m_data, 0);
    step();
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, v2(8, 8), 0, 0);
      step();
      chk("arst_no_cap", c, count, 0);
    end
    drive(1, 0, 0, 0, 0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0);
      step();
    end
    drive(0, 1, v2(5, 9), 0, 0);
    step();
    chk("arst_resume_valid", 0, m_valid, 1);
    chk("arst_resume_data", 0, m_data, v2(5, 9));
    chk("arst_resume_last", 0, m_last, 0);
    chk("arst_resume_count", 0, count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gemm_result_collector.md
Name: gemm_result_collector

Overview:
- Downstream stage of GEMM_Fixed_Weights_Each_Cycle. Consumes one output vector per cycle from the systolic array.
- Aligns each output vector with a "real input" tag injected 2*SA_SIZE cycles earlier and drops bubble results.
- Buffers real results in a FIFO, marks matrix boundaries, and presents them on a valid/ready stream to the writeback path.
- The array has no backpressure, so the collector absorbs stalls and flags losses.

Parameters:
- SA_SIZE, 2, systolic array dimension; vector length.
- WEIGHT_ACTIVATION_SIZE, 8, element width in bits.
- FIFO_DEPTH, 4, result vectors buffered; power of two, at least 2.
- ROWS_PER_MATRIX, 2, real result vectors per output matrix; at least 1.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush.
- in_real  input  1  high when the vector driven into activation_inputs this cycle is real data.
- sa_output_valid  input  1  array output_valid.
- sa_outputs  input  SA_SIZE x WEIGHT_ACTIVATION_SIZE  array activation_outputs.
- m_valid  output  1  result vector available.
- m_ready  input  1  consumer accepts.
- m_data  output  SA_SIZE x WEIGHT_ACTIVATION_SIZE  result vector.
- m_last  output  1  m_data is the final row of a matrix.
- count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- overflow  output  1  sticky: a real result was dropped.

Behaviour:
- Reset: asynchronous, active-low. Clears all registers. m_valid=0, m_last=0, m_data=0, count=0, overflow=0, tag delay line all 0, row counter 0.
- Tag alignment:
  - in_real enters a shift register of depth LAT=2*SA_SIZE.
  - tag_out equals in_real from exactly LAT cycles earlier. It is 0 for the first LAT cycles after reset or clr.
- Capture condition: cap = sa_output_valid && tag_out.
  - Results captured only when cap is high.
  - sa_outputs pass through bit-exact. No arithmetic; wrap-around is already applied by the array.
- Row counter (0..ROWS_PER_MATRIX-1):
  - Advances on every cap, including dropped captures, so matrix framing survives loss.
  - Entry last bit = (row == ROWS_PER_MATRIX-1). The counter wraps to 0 after the last row.
- FIFO:
  - pop = m_valid && m_ready.
  - push = cap && (count < FIFO_DEPTH || pop). A simultaneous push and pop when full is accepted, and count is unchanged.
  - cap && !push sets overflow. overflow stays set until reset or clr.
- Output timing:
  - m_valid = (count != 0). m_data and m_last come from the FIFO head registers.
  - The first captured vector appears on m_valid the cycle after cap, so in_real-to-m_valid latency is LAT+1 cycles.
- Handshake: while m_valid && !m_ready, m_data and m_last hold stable. m_valid never drops without a pop.
- clr:
  - Next cycle: FIFO empty, delay line zeroed, row counter 0, overflow 0.
  - clr overrides push and pop in the same cycle.
- Reset mid-operation: all state is lost and in-flight tags are discarded. After release, captures resume only for in_real asserted after release.
- sa_output_valid low with tag_out high: the tag is discarded, nothing is captured, and the row counter does not advance.

Decomposition:
- Add to GEMM_pkg:
  - function gemm_latency(sa_size) returning 2*sa_size.
  - parameterised struct/typedef for a result entry {last, data vector}.
- One sub-module: gemm_result_fifo. Synchronous FIFO with count output and a simultaneous push/pop-when-full rule, instantiated once.

Test Plan (SA_SIZE=2, LAT=4, FIFO_DEPTH=4, ROWS_PER_MATRIX=2):
- Basic: in_real=1 at cycle 0 only; sa_output_valid=1 and sa_outputs={6,10} at cycle 4. Expect m_valid=1 at cycle 5 with m_data={6,10}, m_last=0, count=1.
- Framing: in_real=1 on cycles 0 and 1; outputs {6,10} then {9,4}; m_ready=1. Expect two beats, m_last=0 then 1, count back to 0.
- Bubble drop: in_real pattern 1,0,1; sa_outputs {1,1},{2,2},{3,3} at cycles 4,5,6. Expect only {1,1} (last=0) and {3,3} (last=1) delivered.
- Backpressure/overflow: m_ready=0 and six consecutive real captures. Expect count=4 holding the first four rows in order. overflow=1 after the 5th capture; rows 5 and 6 are dropped. With m_ready=1, m_last sequence is 0,1,0,1.
- Full push+pop: FIFO full with m_ready=1 and cap in the same cycle. Expect count stays 4, no overflow, and the new row is enqueued at the tail.
- clr/reset: assert clr with count=3 and tags in flight. Next cycle expect m_valid=0, count=0, overflow=0, and no captures for 4 cycles. Repeat with resetn low mid-stream for identical results.
